// File: rtl/memory_bank_be.sv
// memory_bank_be: byte-enable single-port RAM bank with RDW policy, optional output register and clock enable
module memory_bank_be #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDRESS_WIDTH = 10,
  parameter int    RDW_MODE      = 0,
  parameter bit    OUT_REG       = 1'b0,
  parameter string INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     req,
  input  logic                     we,
  input  logic [DATA_WIDTH/8-1:0]  be,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     rvalid
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, merged, s1_data_d, s1_data_q;
  logic                  s1_valid_d, s1_valid_q, acc, wr;
  assign acc     = en & req;
  assign wr      = acc & we;
  assign rd_word = mem_q[addr];
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++)
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
  end
  always_comb begin
    s1_data_d  = !acc ? s1_data_q :
                 (!we || RDW_MODE == 1) ? rd_word :
                 (RDW_MODE == 0) ? merged : s1_data_q;
    s1_valid_d = en ? (req & ~(we & (RDW_MODE == 2))) : s1_valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst_n && wr)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem_q[addr][8*i +: 8] <= din[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end
  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else if (en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= s1_data_q;
      end
    end
    assign dout   = out_data_q;
    assign rvalid = out_valid_q;
  end else begin : g_no_out_reg
    assign dout   = s1_data_q;
    assign rvalid = s1_valid_q;
  end
endmodule
